// File: rtl/regfile_rename_pkg.sv
// Shared constants for the renamed architectural register file.
package regfile_rename_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_REG_WIDTH  = 5;
    localparam int RF_ROB_WIDTH  = 4;
    localparam int RF_REG_SIZE   = 2 ** RF_REG_WIDTH;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Architectural x0: reads as zero, never renamed, never written.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_rename_rf_read_bypass.sv
// One combinational read port with same-cycle commit bypass.
// A busy register whose producing tag is being committed right now is
// shown as ready with the committed value; the highest matching port wins.
module rf_read_bypass
    import regfile_rename_pkg::*;
#(
    parameter int DATA_WIDTH   = RF_DATA_WIDTH,
    parameter int REG_WIDTH    = RF_REG_WIDTH,
    parameter int ROB_WIDTH    = RF_ROB_WIDTH,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic [REG_WIDTH-1:0]                 addr,
    input  logic [DATA_WIDTH-1:0]                ent_val,
    input  logic                                 ent_busy,
    input  logic [ROB_WIDTH-1:0]                 ent_tag,
    input  logic [COMMIT_WIDTH-1:0]              cm_valid,
    input  logic [COMMIT_WIDTH*REG_WIDTH-1:0]    cm_dest,
    input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0]   cm_val,
    input  logic [COMMIT_WIDTH*ROB_WIDTH-1:0]    cm_rob,
    output logic                                 busy,
    output logic [DATA_WIDTH-1:0]                val,
    output logic [ROB_WIDTH-1:0]                 rob
);

    localparam logic [REG_WIDTH-1:0] ZERO_IDX = REG_WIDTH'(ZERO_REG);

    logic                  hit_s;
    logic [DATA_WIDTH-1:0] hit_val_s;

    // Priority search over commit ports; later (younger) ports override earlier ones.
    always_comb begin
        hit_s     = FALSE;
        hit_val_s = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (cm_valid[j] &&
                (cm_dest[j*REG_WIDTH +: REG_WIDTH] == addr) &&
                (cm_rob[j*ROB_WIDTH +: ROB_WIDTH] == ent_tag)) begin
                hit_s     = TRUE;
                hit_val_s = cm_val[j*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                hit_s     = hit_s;
                hit_val_s = hit_val_s;
            end
        end
    end

    // Final read result: x0 forced to zero, bypass only for busy entries.
    always_comb begin
        busy = ent_busy;
        val  = ent_val;
        rob  = ent_tag;
        if (addr == ZERO_IDX) begin
            busy = FALSE;
            val  = '0;
            rob  = '0;
        end else if (ent_busy && hit_s) begin
            busy = FALSE;
            val  = hit_val_s;
        end else begin
            busy = ent_busy;
            val  = ent_val;
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename state (busy + ROB tag).
// Multi-port combinational reads with commit bypass, multi-port commit,
// single dispatch, global flush and a hardwired x0.
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int DATA_WIDTH   = RF_DATA_WIDTH,
    parameter int REG_WIDTH    = RF_REG_WIDTH,
    parameter int ROB_WIDTH    = RF_ROB_WIDTH,
    parameter int NUM_RD       = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 rdy_in,
    input  logic                                 flush_in,
    input  logic                                 dp_valid_in,
    input  logic [REG_WIDTH-1:0]                 dp_rd_in,
    input  logic [ROB_WIDTH-1:0]                 dp_rob_in,
    input  logic [NUM_RD*REG_WIDTH-1:0]          rd_addr_in,
    output logic [NUM_RD-1:0]                    rd_busy_out,
    output logic [NUM_RD*DATA_WIDTH-1:0]         rd_val_out,
    output logic [NUM_RD*ROB_WIDTH-1:0]          rd_rob_out,
    input  logic [COMMIT_WIDTH-1:0]              cm_valid_in,
    input  logic [COMMIT_WIDTH*REG_WIDTH-1:0]    cm_dest_in,
    input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0]   cm_val_in,
    input  logic [COMMIT_WIDTH*ROB_WIDTH-1:0]    cm_rob_in
);

    localparam int                   REG_SIZE = 2 ** REG_WIDTH;
    localparam logic [REG_WIDTH-1:0] ZERO_IDX = REG_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] value_r      [REG_SIZE];
    logic [DATA_WIDTH-1:0] value_next_s [REG_SIZE];
    logic [ROB_WIDTH-1:0]  tag_r        [REG_SIZE];
    logic [ROB_WIDTH-1:0]  tag_next_s   [REG_SIZE];
    logic [REG_SIZE-1:0]   busy_r;
    logic [REG_SIZE-1:0]   busy_next_s;

    logic [REG_WIDTH-1:0]  cm_dest_s [COMMIT_WIDTH];
    logic [DATA_WIDTH-1:0] cm_val_s  [COMMIT_WIDTH];
    logic [ROB_WIDTH-1:0]  cm_rob_s  [COMMIT_WIDTH];

    for (genvar j = 0; j < COMMIT_WIDTH; j++) begin : g_cm
        assign cm_dest_s[j] = cm_dest_in[j*REG_WIDTH +: REG_WIDTH];
        assign cm_val_s[j]  = cm_val_in[j*DATA_WIDTH +: DATA_WIDTH];
        assign cm_rob_s[j]  = cm_rob_in[j*ROB_WIDTH +: ROB_WIDTH];
    end

    // Next state: commits in port order, then flush or dispatch on top.
    // Busy clears are judged against the tag held before this cycle's dispatch.
    always_comb begin
        value_next_s = value_r;
        tag_next_s   = tag_r;
        busy_next_s  = busy_r;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (cm_valid_in[j] && (cm_dest_s[j] != ZERO_IDX)) begin
                value_next_s[cm_dest_s[j]] = cm_val_s[j];
                busy_next_s[cm_dest_s[j]]  = busy_next_s[cm_dest_s[j]] &
                                             (tag_r[cm_dest_s[j]] != cm_rob_s[j]);
            end else begin
                value_next_s = value_next_s;
            end
        end
        if (flush_in) begin
            busy_next_s = '0;
        end else if (dp_valid_in && (dp_rd_in != ZERO_IDX)) begin
            tag_next_s[dp_rd_in]  = dp_rob_in;
            busy_next_s[dp_rd_in] = TRUE;
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // State registers: async clear, update only while the pipeline is ready.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < REG_SIZE; r++) begin
                value_r[r] <= '0;
                tag_r[r]   <= '0;
            end
            busy_r <= '0;
        end else if (rdy_in) begin
            value_r <= value_next_s;
            tag_r   <= tag_next_s;
            busy_r  <= busy_next_s;
        end else begin
            value_r <= value_r;
            tag_r   <= tag_r;
            busy_r  <= busy_r;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [REG_WIDTH-1:0] addr_s;
        assign addr_s = rd_addr_in[i*REG_WIDTH +: REG_WIDTH];

        rf_read_bypass #(
            .DATA_WIDTH   (DATA_WIDTH),
            .REG_WIDTH    (REG_WIDTH),
            .ROB_WIDTH    (ROB_WIDTH),
            .COMMIT_WIDTH (COMMIT_WIDTH)
        ) u_rd (
            .addr     (addr_s),
            .ent_val  (value_r[addr_s]),
            .ent_busy (busy_r[addr_s]),
            .ent_tag  (tag_r[addr_s]),
            .cm_valid (cm_valid_in),
            .cm_dest  (cm_dest_in),
            .cm_val   (cm_val_in),
            .cm_rob   (cm_rob_in),
            .busy     (rd_busy_out[i]),
            .val      (rd_val_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .rob      (rd_rob_out[i*ROB_WIDTH +: ROB_WIDTH])
        );
    end

endmodule
